hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard and forwarding scoreboard for the MIPS pipeline. It replaces the fixed load-use stall logic and the fixed two-level bypass selection with one tracker. The tracker records every in-flight register write across a configurable number of post-decode stages and knows when each result becomes forwardable, which depends on whether the producer is an ALU op or a load. It sits beside the decode stage. It drives the PC, IF/ID and control enables, plus the operand bypass selects, and keeps a stall performance counter.

## Interface
Parameters:
- REG_BITS, 5: register index width.
- DEPTH, 3: number of tracked stages after decode (stage 0 = EX, 1 = MEM, 2 = WB); legal range 2..8.
- ALU_READY, 0: first stage index whose output carries an ALU result.
- LOAD_READY, 1: first stage index whose output carries load data; must be ≥ ALU_READY and < DEPTH.
- SEL_BITS, $clog2(DEPTH+1): width of the forward selects.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- issue_valid  in  1  the decode-stage instruction is real and not a bubble.
- issue_we  in  1  the decode-stage instruction writes a register.
- issue_is_load  in  1  the decode-stage instruction is a load.
- issue_rd  in  REG_BITS  destination register of the decode-stage instruction.
- src_a, src_b  in  REG_BITS  source registers read in decode.
- src_a_used, src_b_used  in  1  qualify src_a and src_b.
- flush  in  1  kill the decode-stage instruction (taken branch or jump).
- stall  out  1  hold PC and IF/ID and insert a bubble; combinational.
- fwd_a, fwd_b  out  SEL_BITS  0 = register file; k = output of stage k-1; combinational.
- stall_count  out  32  saturating count of stalled cycles; registered.

## Operation
- State: DEPTH entries, each holding {valid, rd, is_load}. Entry 0 is the youngest and sits in EX.
- An entry is tracked only if valid && we && rd != 0. Register 0 is never tracked and never matched.
- Match rule for src_x, when used:
  - Scan entries 0..DEPTH-1 and take the youngest valid entry with rd == src_x. Older matches are ignored.
  - Let k be the matched entry and r = LOAD_READY if it is a load, ALU_READY otherwise.
  - If k ≥ r, set fwd_x = k+1 and do not stall for this source.
  - If k < r, this source requests a stall and fwd_x = 0.
  - If no entry matches, fwd_x = 0.
- stall = (src_a request || src_b request) && issue_valid && !flush. While stall is high, fwd_a and fwd_b are forced to 0.
- Shift on every edge: entry k moves to k+1 and entry DEPTH-1 retires.
- Entry 0 is loaded from the issue fields when issue_valid && !stall && !flush. Otherwise entry 0 becomes a bubble (valid = 0).
- stall_count increments on each cycle with stall high and saturates at 0xFFFF_FFFF.

## Timing
- Reset: on any edge with rst high, all entries become invalid and stall_count = 0. The same cycle's issue is discarded. Reset mid-stall drops the pending hazard.
- After reset: stall = 0, fwd_a = fwd_b = 0, and they stay so until the first tracked issue.
- Latency: stall and fwd follow the inputs and current state in the same cycle, with no registered delay.
- The stall decision in cycle n reflects entries captured at edge n-1.
- Load-use with the defaults: a consumer directly behind a load stalls exactly 1 cycle, then receives fwd = 2.
- ALU-use with the defaults: no stall; fwd = 1.
- flush and stall in the same cycle: flush wins, stall = 0, a bubble is inserted and stall_count does not increment.
- A stalled instruction re-evaluates each cycle. The stall never exceeds LOAD_READY cycles.

## Structure
- The shared pipeline package holds:
  - the entry record type {valid, rd, is_load};
  - the localparam FWD_REGFILE = 0;
  - the helper function for ready_stage(is_load).
- One sub-module, hazard_match: a combinational youngest-match priority encoder, instantiated once per source operand. The scoreboard top owns the shift register and the counter.

## Test plan
- Reset mid-operation: issue a load to r7, assert rst on the next edge, then present src_a = 7 -> stall = 0, fwd_a = 0, stall_count = 0.
- ALU forward: issue an ALU op to r5, then next cycle src_a = 5 -> stall = 0, fwd_a = 1; one cycle later fwd_a = 2, then 3, then 0 once retired.
- Load-use: issue a load to r7, then src_b = 7 -> stall = 1 for one cycle with stall_count = 1, then stall = 0, fwd_b = 2.
- Youngest wins: write r3 with an ALU op twice back-to-back, then src_a = 3 -> fwd_a = 1, not 2. Both sources on r3 -> fwd_a = fwd_b = 1.
- r0 and unused operands: issue writes to r0, then src_a = 0 -> fwd_a = 0. A load to r4 followed by src_b = 4 with src_b_used = 0 -> no stall.
- Flush during a load-use stall: stall drops to 0 that cycle, a bubble enters entry 0 and stall_count stays unchanged. DEPTH = 5, LOAD_READY = 3 build: a load-use produces exactly 3 stall cycles, then fwd = 4.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and helpers for the decode-side hazard/forwarding scoreboard.
package hazard_scoreboard_pkg;

   localparam int MAX_REG_BITS = 8;
   localparam int FWD_REGFILE  = 0;

   // One tracked in-flight register write; rd is zero-extended to MAX_REG_BITS.
   typedef struct packed {
      logic                    valid;
      logic [MAX_REG_BITS-1:0] rd;
      logic                    is_load;
   } entry_t;

   function automatic int ready_stage(input logic is_load, input int alu_ready, input int load_ready);
      return is_load ? load_ready : alu_ready;
   endfunction

endpackage

// File: rtl/hazard_match.sv
// Youngest-match priority encoder for one source operand; purely combinational.
// Produces a stall request when the producer's result is not yet forwardable.
module hazard_match
   import hazard_scoreboard_pkg::*;
#(
   parameter int REG_BITS   = 5,
   parameter int DEPTH      = 3,
   parameter int ALU_READY  = 0,
   parameter int LOAD_READY = 1,
   parameter int SEL_BITS   = $clog2(DEPTH + 1)
) (
   input  entry_t [DEPTH-1:0]   entries,
   input  logic [REG_BITS-1:0]  src,
   input  logic                 used,
   output logic                 req,
   output logic [SEL_BITS-1:0]  fwd
);

   logic found;

   always_comb begin
      req   = 1'b0;
      fwd   = SEL_BITS'(FWD_REGFILE);
      found = 1'b0;
      // First hit in age order is the youngest producer; older ones are shadowed.
      for (int k = 0; k < DEPTH; k++) begin
         if (!found && used && (src != '0) && entries[k].valid &&
             (entries[k].rd == MAX_REG_BITS'(src))) begin
            found = 1'b1;
            if (k >= ready_stage(entries[k].is_load, ALU_READY, LOAD_READY))
               fwd = SEL_BITS'(k + 1);
            else
               req = 1'b1;
         end
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writes beside decode; stall/forward selects are same-cycle combinational.
// Stalls hold decode until every used source is forwardable; flush overrides stall.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int REG_BITS   = 5,
   parameter int DEPTH      = 3,
   parameter int ALU_READY  = 0,
   parameter int LOAD_READY = 1,
   parameter int SEL_BITS   = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 issue_valid,
   input  logic                 issue_we,
   input  logic                 issue_is_load,
   input  logic [REG_BITS-1:0]  issue_rd,
   input  logic [REG_BITS-1:0]  src_a,
   input  logic [REG_BITS-1:0]  src_b,
   input  logic                 src_a_used,
   input  logic                 src_b_used,
   input  logic                 flush,
   output logic                 stall,
   output logic [SEL_BITS-1:0]  fwd_a,
   output logic [SEL_BITS-1:0]  fwd_b,
   output logic [31:0]          stall_count
);

   entry_t [DEPTH-1:0]  entries;
   entry_t              new_entry;
   logic                req_a;
   logic                req_b;
   logic [SEL_BITS-1:0] raw_fwd_a;
   logic [SEL_BITS-1:0] raw_fwd_b;

   hazard_match #(
      .REG_BITS   (REG_BITS),
      .DEPTH      (DEPTH),
      .ALU_READY  (ALU_READY),
      .LOAD_READY (LOAD_READY),
      .SEL_BITS   (SEL_BITS)
   ) u_match_a (
      .entries (entries),
      .src     (src_a),
      .used    (src_a_used),
      .req     (req_a),
      .fwd     (raw_fwd_a)
   );

   hazard_match #(
      .REG_BITS   (REG_BITS),
      .DEPTH      (DEPTH),
      .ALU_READY  (ALU_READY),
      .LOAD_READY (LOAD_READY),
      .SEL_BITS   (SEL_BITS)
   ) u_match_b (
      .entries (entries),
      .src     (src_b),
      .used    (src_b_used),
      .req     (req_b),
      .fwd     (raw_fwd_b)
   );

   always_comb begin
      stall = (req_a || req_b) && issue_valid && !flush;
      fwd_a = stall ? SEL_BITS'(FWD_REGFILE) : raw_fwd_a;
      fwd_b = stall ? SEL_BITS'(FWD_REGFILE) : raw_fwd_b;
   end

   // Non-writing, r0-writing, stalled or flushed issues all enter as bubbles.
   always_comb begin
      new_entry.valid   = issue_valid && issue_we && (issue_rd != '0) && !stall && !flush;
      new_entry.rd      = MAX_REG_BITS'(issue_rd);
      new_entry.is_load = issue_is_load;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         entries     <= '0;
         stall_count <= '0;
      end else begin
         for (int k = DEPTH - 1; k > 0; k--)
            entries[k] <= entries[k-1];
         entries[0] <= new_entry;
         if (stall && (stall_count != 32'hFFFF_FFFF))
            stall_count <= stall_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Drives two scoreboard builds (default and DEPTH=5/LOAD_READY=3) with shared stimulus,
// predicting stall/forward/count from a log of captured producers keyed by capture cycle.
module tb_hazard_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid, issue_we, issue_is_load, flush;
   logic [4:0]  issue_rd, src_a, src_b;
   logic        src_a_used, src_b_used;

   logic        stall0, stall1;
   logic [1:0]  fwd_a0, fwd_b0;
   logic [2:0]  fwd_a1, fwd_b1;
   logic [31:0] cnt0, cnt1;

   always #5 clk = ~clk;

   hazard_scoreboard #(.REG_BITS(5), .DEPTH(3), .ALU_READY(0), .LOAD_READY(1)) dut0 (
      .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_we(issue_we),
      .issue_is_load(issue_is_load), .issue_rd(issue_rd), .src_a(src_a), .src_b(src_b),
      .src_a_used(src_a_used), .src_b_used(src_b_used), .flush(flush),
      .stall(stall0), .fwd_a(fwd_a0), .fwd_b(fwd_b0), .stall_count(cnt0));

   hazard_scoreboard #(.REG_BITS(5), .DEPTH(5), .ALU_READY(0), .LOAD_READY(3)) dut1 (
      .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_we(issue_we),
      .issue_is_load(issue_is_load), .issue_rd(issue_rd), .src_a(src_a), .src_b(src_b),
      .src_a_used(src_a_used), .src_b_used(src_b_used), .flush(flush),
      .stall(stall1), .fwd_a(fwd_a1), .fwd_b(fwd_b1), .stall_count(cnt1));

   typedef struct {int t; int rd; bit ld;} prod_t;
   typedef struct {bit s0; int fa0; int fb0; longint c0; bit s1; int fa1; int fb1; longint c1;} exp_t;

   prod_t  log0[$];
   prod_t  log1[$];
   exp_t   expq[$];
   int     checks = 0;
   int     errors = 0;
   int     cyc = 0;
   longint mcnt0 = 0;
   longint mcnt1 = 0;
   bit     es0 = 0;
   bit     es1 = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // Age of a producer = cycles since the edge that captured it; stage index = age.
   function automatic void lookup(input prod_t q[$], input int depth, input int load_r,
                                  input int src, input bit used, output bit req, output int fwd);
      int best_t = -1;
      bit ld = 0;
      req = 0;
      fwd = 0;
      foreach (q[i])
         if (q[i].rd == src && (cyc - q[i].t) < depth && q[i].t > best_t) begin
            best_t = q[i].t;
            ld = q[i].ld;
         end
      if (used && src != 0 && best_t >= 0) begin
         if ((cyc - best_t) < (ld ? load_r : 0)) req = 1;
         else fwd = cyc - best_t + 1;
      end
   endfunction

   function automatic void predict(input prod_t q[$], input int depth, input int load_r,
                                   output bit s, output int fa, output int fb);
      bit ra, rb;
      lookup(q, depth, load_r, int'(src_a), src_a_used, ra, fa);
      lookup(q, depth, load_r, int'(src_b), src_b_used, rb, fb);
      s = (ra || rb) && issue_valid && !flush;
      if (s) begin
         fa = 0;
         fb = 0;
      end
   endfunction

   function automatic longint sat_inc(input longint c);
      return (c >= 64'hFFFF_FFFF) ? c : c + 1;
   endfunction

   // Apply what the edge just captured, using the inputs that were present before it.
   task automatic edge_update();
      bit wr;
      cyc++;
      wr = issue_valid && issue_we && issue_rd != 0 && !flush;
      if (rst) begin
         log0.delete();
         log1.delete();
         mcnt0 = 0;
         mcnt1 = 0;
      end else begin
         if (es0) mcnt0 = sat_inc(mcnt0);
         if (es1) mcnt1 = sat_inc(mcnt1);
         if (wr && !es0) log0.push_back('{cyc, int'(issue_rd), issue_is_load});
         if (wr && !es1) log1.push_back('{cyc, int'(issue_rd), issue_is_load});
      end
      while (log0.size() > 0 && cyc - log0[0].t >= 3) void'(log0.pop_front());
      while (log1.size() > 0 && cyc - log1[0].t >= 5) void'(log1.pop_front());
   endtask

   task automatic push_expect();
      exp_t e;
      predict(log0, 3, 1, e.s0, e.fa0, e.fb0);
      predict(log1, 5, 3, e.s1, e.fa1, e.fb1);
      e.c0 = mcnt0;
      e.c1 = mcnt1;
      es0 = e.s0;
      es1 = e.s1;
      expq.push_back(e);
   endtask

   task automatic drive(input bit v, input bit we, input bit ld, input int rd,
                        input int a, input bit au, input int b, input bit bu,
                        input bit fl, input bit r);
      @(posedge clk);
      edge_update();
      #1;
      issue_valid = v; issue_we = we; issue_is_load = ld; issue_rd = 5'(rd);
      src_a = 5'(a); src_a_used = au; src_b = 5'(b); src_b_used = bu;
      flush = fl; rst = r;
      push_expect();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            check("stall_d3", stall0, e.s0);
            check("fwd_a_d3", fwd_a0, e.fa0);
            check("fwd_b_d3", fwd_b0, e.fb0);
            check("count_d3", cnt0, e.c0);
            check("stall_d5", stall1, e.s1);
            check("fwd_a_d5", fwd_a1, e.fa1);
            check("fwd_b_d5", fwd_b1, e.fb1);
            check("count_d5", cnt1, e.c1);
         end
      end
   end

   initial begin : stimulus
      bit v, we, ld, au, bu;
      int rd, a, b;
      rst = 1; issue_valid = 0; issue_we = 0; issue_is_load = 0; issue_rd = 0;
      src_a = 0; src_b = 0; src_a_used = 0; src_b_used = 0; flush = 0;
      @(posedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(2);

      // reset mid-operation
      drive(1, 1, 1, 7, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      drive(1, 0, 0, 0, 7, 1, 0, 0, 0, 0);
      idle(2);
      // ALU forward through every stage and retirement
      drive(1, 1, 0, 5, 0, 0, 0, 0, 0, 0);
      repeat (6) drive(1, 0, 0, 0, 5, 1, 0, 0, 0, 0);
      // load-use, consumer held until released
      drive(1, 1, 1, 7, 0, 0, 0, 0, 0, 0);
      repeat (6) drive(1, 0, 0, 0, 0, 0, 7, 1, 0, 0);
      // youngest wins, both sources
      drive(1, 1, 0, 3, 0, 0, 0, 0, 0, 0);
      drive(1, 1, 0, 3, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 3, 1, 3, 1, 0, 0);
      // r0 writes and unused operand
      drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
      drive(1, 1, 1, 4, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 4, 0, 0, 0);
      // flush during a load-use stall
      drive(1, 1, 1, 6, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 6, 1, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 6, 1, 0, 0, 1, 0);
      drive(1, 0, 0, 0, 6, 1, 0, 0, 0, 0);
      idle(5);

      v = 0; we = 0; ld = 0; rd = 0; a = 0; au = 0; b = 0; bu = 0;
      for (int i = 0; i < 3000; i++) begin
         // a stalled instruction is usually re-presented unchanged
         if (!(es0 && $urandom_range(0, 3) != 0)) begin
            v  = $urandom_range(0, 9) != 0;
            we = $urandom_range(0, 3) != 0;
            ld = $urandom_range(0, 2) == 0;
            rd = $urandom_range(0, 7);
            a  = $urandom_range(0, 7);
            b  = $urandom_range(0, 7);
            au = $urandom_range(0, 4) != 0;
            bu = $urandom_range(0, 4) != 0;
         end
         drive(v, we, ld, rd, a, au, b, bu, $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
      end
      idle(2);
      @(negedge clk);
      @(negedge clk);
      check("queue_drained", expq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
